loctag_reflector_mc: RTL and testbench

Multi-channel, triggered reflector modulation sequencer for the LocTag core. It replaces the single `ctrl_1` reflector drive with `NUM_CH` independently timed RF-switch controls. On each accepted detector trigger it runs one timed frequency-shift burst in the selected mode, then a hold-off. It sits between the detector/trigger path and the reflector switch pins, clocked by the PLL output clock.

---
 rtl/loctag_pkg.sv | 19 +
 rtl/loctag_toggle_gen.sv | 31 +++
 rtl/loctag_reflector_mc.sv | 152 +++++++++++++++
 tb/tb_loctag_reflector_mc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loctag_pkg.sv
// Shared types and constants for the LocTag reflector sequencer.
// FSM state encoding, burst mode codes and counter widths.
package loctag_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        HOLDOFF,
        FORCE
    } state_t;

    localparam logic [1:0] MODE_INPHASE = 2'd0;
    localparam logic [1:0] MODE_FDIV    = 2'd1;
    localparam logic [1:0] MODE_RR      = 2'd2;
    localparam logic [1:0] MODE_OFF     = 2'd3;

    localparam int TRIG_CNT_W = 8;

endpackage

// File: rtl/loctag_toggle_gen.sv
// One reflector channel: half-period counter plus output flop.
// cnt==0 marks an idle channel so the first enabled cycle drives 1.
module loctag_toggle_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] half,
    output logic         out
);

    logic [W-1:0] cnt;

    // start high when enabled, invert every half cycles, clear when disabled
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            out <= 1'b0;
            cnt <= '0;
        end else if (cnt == '0) begin
            out <= 1'b1;
            cnt <= W'(1);
        end else if (cnt >= half) begin
            out <= ~out;
            cnt <= W'(1);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/loctag_reflector_mc.sv
// Multi-channel triggered reflector modulation sequencer.
// Optional accepted-trigger counter port: LOCTAG_TRIG_CNT_EN.
module loctag_reflector_mc
    import loctag_pkg::*;
#(
    parameter int NUM_CH           = 3,
    parameter int HALF_PERIOD_BASE = 25,
    parameter int BURST_CYC        = 50000,
    parameter int HOLDOFF_CYC      = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic              force_fs,
    input  logic [1:0]        mode,
    output logic [NUM_CH-1:0] ctrl,
    output logic              busy,
    output logic              led
`ifdef LOCTAG_TRIG_CNT_EN
    ,
    output logic [TRIG_CNT_W-1:0] trig_cnt
`endif
);

    localparam int CNT_MAX = (BURST_CYC > HOLDOFF_CYC) ? BURST_CYC : HOLDOFF_CYC;
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HW = $clog2(HALF_PERIOD_BASE * NUM_CH + 1);

    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_CYC - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_CH - 1);

    logic              sync1, sync2, sync3;
    logic              trig_edge;
    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CW-1:0]     cnt_q;
    logic [SW-1:0]     slot_q, slot_d;
    logic              slot_end, burst_end;
    logic [NUM_CH-1:0] ch_en;

    assign slot_end  = (cnt_q == BURST_LAST);
    assign burst_end = slot_end && (mode_q != MODE_RR || slot_q == SLOT_LAST);
    assign mode_d    = (state_q == IDLE && state_d == BURST) ? mode : mode_q;

    // two-flop synchronizer, delay flop and registered rising-edge pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            trig_edge <= 1'b0;
        end else begin
            sync1     <= trig;
            sync2     <= sync1;
            sync3     <= sync2;
            trig_edge <= sync2 & ~sync3;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state: force overrides everything, trig edges only count in IDLE
    always_comb begin
        state_d = state_q;
        if (force_fs) begin
            state_d = FORCE;
        end else begin
            unique case (state_q)
                IDLE:    if (trig_edge && mode != MODE_OFF) state_d = BURST;
                BURST:   if (burst_end) state_d = HOLDOFF;
                HOLDOFF: if (cnt_q == HOLD_LAST) state_d = IDLE;
                FORCE:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // slot index the channels will see next cycle
    always_comb begin
        slot_d = '0;
        if (state_q == BURST && state_d == BURST)
            slot_d = slot_end ? slot_q + 1'b1 : slot_q;
    end

    // cycle counter within the current slot or hold-off, latched mode
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            slot_q <= '0;
            mode_q <= MODE_INPHASE;
        end else begin
            mode_q <= mode_d;
            slot_q <= slot_d;
            if (state_d == state_q && state_q == HOLDOFF)
                cnt_q <= cnt_q + 1'b1;
            else if (state_d == state_q && state_q == BURST && !slot_end)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
        end
    end

    // outputs: enables follow the next state so ctrl moves with the state
    always_comb begin
        busy  = (state_q == BURST) || (state_q == HOLDOFF);
        led   = (state_q != IDLE);
        ch_en = '0;
        if (state_d == FORCE) begin
            ch_en = '1;
        end else if (state_d == BURST) begin
            if (mode_d == MODE_RR) begin
                for (int k = 0; k < NUM_CH; k++)
                    ch_en[k] = (slot_d == SW'(k));
            end else begin
                ch_en = '1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [HW-1:0] half;

        assign half = (state_d == BURST && mode_d == MODE_FDIV) ?
                      HW'(HALF_PERIOD_BASE * (k + 1)) :
                      HW'(HALF_PERIOD_BASE);

        loctag_toggle_gen #(.W(HW)) u_tg (
            .clk   (clk),
            .reset (reset),
            .en    (ch_en[k]),
            .half  (half),
            .out   (ctrl[k])
        );
    end

`ifdef LOCTAG_TRIG_CNT_EN
    // saturating count of IDLE -> BURST transitions
    always_ff @(posedge clk) begin
        if (reset)
            trig_cnt <= '0;
        else if (state_q == IDLE && state_d == BURST && trig_cnt != '1)
            trig_cnt <= trig_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_loctag_reflector_mc.sv
// Bench for loctag_reflector_mc: vector table, directed sequences,
// random stimulus against a timeline model of the sequencer.
module tb_loctag_reflector_mc;

    localparam int NC = 3;
    localparam int HP = 4;
    localparam int BC = 48;
    localparam int HC = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          trig = 1'b0;
    logic          force_fs = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [NC-1:0] ctrl;
    logic          busy;
    logic          led;
`ifdef LOCTAG_TRIG_CNT_EN
    logic [7:0]    trig_cnt;
`endif

    int n_chk = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    loctag_reflector_mc #(
        .NUM_CH(NC), .HALF_PERIOD_BASE(HP),
        .BURST_CYC(BC), .HOLDOFF_CYC(HC)
    ) dut (
        .clk(clk), .reset(reset), .trig(trig),
        .force_fs(force_fs), .mode(mode),
        .ctrl(ctrl), .busy(busy), .led(led)
`ifdef LOCTAG_TRIG_CNT_EN
        , .trig_cnt(trig_cnt)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_BURST, M_HOLD, M_FORCE} mst_t;
    mst_t m_st = M_IDLE;
    int   m_t, m_h, m_ft, m_mode, m_cnt;
    bit   m_known = 1'b1;
    bit   s1, s2, s3, s4;

    function automatic int burst_len(input int md);
        return (md == 2) ? NC * BC : BC;
    endfunction

    function automatic logic [NC-1:0] burst_ctrl(input int md, input int t);
        logic [NC-1:0] r;
        r = '0;
        for (int k = 0; k < NC; k++) begin
            case (md)
                0: r[k] = ((t / HP) % 2) == 0;
                1: r[k] = ((t / (HP * (k + 1))) % 2) == 0;
                default: r[k] = (t / BC == k) && (((t % BC) / HP) % 2 == 0);
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        bit e;
        logic [NC-1:0] ex;
        bit kn;
        if (reset) begin
            m_st = M_IDLE; m_cnt = 0; m_known = 1'b1;
            s1 = 0; s2 = 0; s3 = 0; s4 = 0;
        end else begin
            e = s3 & ~s4;
            s4 = s3; s3 = s2; s2 = s1; s1 = trig;
            if (force_fs) begin
                if (m_st == M_BURST && m_mode == 0) begin
                    m_ft = m_t + 1; m_known = 1'b1;
                end else if (m_st == M_BURST) begin
                    m_known = 1'b0;
                end else if (m_st != M_FORCE) begin
                    m_ft = 0; m_known = 1'b1;
                end else begin
                    m_ft++;
                end
                m_st = M_FORCE;
            end else begin
                case (m_st)
                    M_IDLE: if (e && mode != 2'd3) begin
                        m_st = M_BURST; m_mode = int'(mode); m_t = 0;
                        if (m_cnt < 255) m_cnt++;
                    end
                    M_BURST: begin
                        m_t++;
                        if (m_t == burst_len(m_mode)) begin m_st = M_HOLD; m_h = 0; end
                    end
                    M_HOLD: begin
                        m_h++;
                        if (m_h == HC) m_st = M_IDLE;
                    end
                    default: begin m_st = M_IDLE; m_known = 1'b1; end
                endcase
            end
        end
        if (mon_en) begin
            #1;
            kn = 1'b1;
            ex = '0;
            if (m_st == M_BURST) ex = burst_ctrl(m_mode, m_t);
            if (m_st == M_FORCE) begin
                kn = m_known;
                ex = (((m_ft / HP) % 2) == 0) ? '1 : '0;
            end
            check("mon_busy", int'(busy), int'(m_st == M_BURST || m_st == M_HOLD));
            check("mon_led", int'(led), int'(m_st != M_IDLE));
            if (kn) check("mon_ctrl", int'(ctrl), int'(ex));
`ifdef LOCTAG_TRIG_CNT_EN
            check("mon_trig_cnt", int'(trig_cnt), m_cnt);
`endif
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        int md; int busy_len; int lat;
        int hi0; int hi1; int hi2;
        int r0; int r1; int r2;
        int max_on;
    } vec_t;

    vec_t vecs[4];

    task automatic reset_dut();
        reset = 1'b1; trig = 1'b0; force_fs = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat, bl, on, mx;
        int hi[NC];
        int rs[NC];
        logic [NC-1:0] prev;
        lat = -1; bl = 0; mx = 0; prev = '0;
        for (int k = 0; k < NC; k++) begin hi[k] = 0; rs[k] = 0; end
        mode = 2'(v.md);
        trig = 1'b1;
        for (int c = 0; c < 240; c++) begin
            step();
            if (c == 1) trig = 1'b0;
            if (ctrl != '0 && lat < 0) lat = c;
            if (busy) bl++;
            on = $countones(ctrl);
            if (on > mx) mx = on;
            for (int k = 0; k < NC; k++) begin
                if (ctrl[k]) hi[k]++;
                if (ctrl[k] && !prev[k]) rs[k]++;
            end
            prev = ctrl;
        end
        check($sformatf("m%0d_busy_len", v.md), bl, v.busy_len);
        check($sformatf("m%0d_latency", v.md), lat, v.lat);
        check($sformatf("m%0d_hi0", v.md), hi[0], v.hi0);
        check($sformatf("m%0d_hi1", v.md), hi[1], v.hi1);
        check($sformatf("m%0d_hi2", v.md), hi[2], v.hi2);
        check($sformatf("m%0d_rise0", v.md), rs[0], v.r0);
        check($sformatf("m%0d_rise1", v.md), rs[1], v.r1);
        check($sformatf("m%0d_rise2", v.md), rs[2], v.r2);
        check($sformatf("m%0d_max_on", v.md), mx, v.max_on);
    endtask

    initial begin
        int bl, hi, rs, neq, bz, ld;
        logic p;

        vecs[0] = '{0, 64, 3, 24, 24, 24, 6, 6, 6, 3};
        vecs[1] = '{1, 64, 3, 24, 24, 24, 6, 3, 2, 3};
        vecs[2] = '{2, 160, 3, 24, 24, 24, 6, 6, 6, 1};
        vecs[3] = '{3, 0, -1, 0, 0, 0, 0, 0, 0, 0};

        // reset state
        step(); step();
        check("rst_ctrl", int'(ctrl), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_led", int'(led), 0);
`ifdef LOCTAG_TRIG_CNT_EN
        check("rst_trig_cnt", int'(trig_cnt), 0);
`endif
        mon_en = 1'b1;
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            reset_dut();
            run_vec(vecs[i]);
        end

        // dropped edges in BURST/HOLDOFF, accepted on first IDLE cycle
        reset_dut();
        mode = 2'd0; trig = 1'b1; bl = 0;
        for (int c = 0; c < 140; c++) begin
            step();
            trig = (c == 10 || c == 11 || c == 53 || c == 54 || c == 64);
            if (c <= 67 && busy) bl++;
            if (c == 66) check("seq_busy_last_hold", int'(busy), 1);
            if (c == 67) check("seq_busy_first_idle", int'(busy), 0);
            if (c == 68) check("seq_busy_rearm", int'(busy), 1);
`ifdef LOCTAG_TRIG_CNT_EN
            if (c == 67) check("seq_trig_cnt1", int'(trig_cnt), 1);
            if (c == 70) check("seq_trig_cnt2", int'(trig_cnt), 2);
`endif
        end
        check("seq_busy_len", bl, 64);

        // edge on the HOLDOFF -> IDLE cycle is dropped
        reset_dut();
        mode = 2'd0; trig = 1'b1; bl = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            trig = (c == 63);
            if (c >= 67 && busy) bl++;
        end
        check("seq_edge_at_exit_dropped", bl, 0);

        // force mid-burst, then release
        reset_dut();
        mode = 2'd0; trig = 1'b1;
        hi = 0; rs = 0; neq = 0; bz = 0; ld = 0; p = 1'b0;
        for (int c = 0; c <= 60; c++) begin
            step();
            if (c == 1) trig = 1'b0;
            if (c >= 21) begin
                if (ctrl[0]) hi++;
                if (ctrl[0] && !p) rs++;
                if (ctrl != {NC{ctrl[0]}}) neq++;
                if (busy) bz++;
                if (led) ld++;
            end
            p = ctrl[0];
            if (c == 20) force_fs = 1'b1;
        end
        check("force_hi", hi, 20);
        check("force_rises", rs, 5);
        check("force_ch_equal", neq, 0);
        check("force_busy", bz, 0);
        check("force_led", ld, 40);
        force_fs = 1'b0;
        step();
        check("force_rel_ctrl", int'(ctrl), 0);
        check("force_rel_led", int'(led), 0);

        // reset mid-burst
        reset_dut();
        mode = 2'd1; trig = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            step();
            if (c == 1) trig = 1'b0;
        end
        check("rb_busy_before", int'(busy), 1);
        reset = 1'b1;
        step();
        check("rb_ctrl", int'(ctrl), 0);
        check("rb_busy", int'(busy), 0);
        check("rb_led", int'(led), 0);
        reset = 1'b0;

        // random stimulus checked by the model
        begin
            int f_left;
            f_left = 0;
            for (int c = 0; c < 4000; c++) begin
                step();
                reset = ($urandom_range(0, 1999) == 0);
                if ($urandom_range(0, 11) == 0) trig = ~trig;
                if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
                if (f_left > 0) begin
                    f_left--;
                    if (f_left == 0) force_fs = 1'b0;
                end else if ($urandom_range(0, 499) == 0) begin
                    force_fs = 1'b1;
                    f_left = $urandom_range(3, 30);
                end
            end
        end
        reset = 1'b0; force_fs = 1'b0; trig = 1'b0;
        step(); step();
        mon_en = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
